// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions,
// condition codes, status codes and the "no register" id.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [2:0] S_AOK = 3'h1;
   localparam logic [2:0] S_HLT = 3'h2;
   localparam logic [2:0] S_ADR = 3'h3;
   localparam logic [2:0] S_INS = 3'h4;

   localparam logic [3:0] RNONE = 4'hF;

   // An exception (or halt) further down the pipe freezes the CC.
   function automatic logic stat_blocks_cc(input logic [2:0] s);
      return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
   endfunction

endpackage

// File: rtl/alu_pipe.sv
// Combinational Y86-64 ALU: valE = aluB op aluA, plus Z/S/O flags.
// Ports: alu_a, alu_b, alufun in; val_e, zf, sf, of out.
module alu_pipe
   import y86_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [3:0]       alufun,
   output logic [WIDTH-1:0] val_e,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   logic sa, sb, sr;

   assign sa = alu_a[WIDTH-1];
   assign sb = alu_b[WIDTH-1];
   assign sr = val_e[WIDTH-1];

   always_comb begin
      val_e = '0;
      of    = 1'b0;
      unique case (alufun)
         ALU_ADD: begin
            val_e = alu_b + alu_a;
            of    = (sa == sb) && (sr != sa);
         end
         ALU_SUB: begin
            val_e = alu_b - alu_a;
            of    = (sa != sb) && (sr != sb);
         end
         ALU_AND: val_e = alu_b & alu_a;
         ALU_XOR: val_e = alu_b ^ alu_a;
         default: begin
            val_e = '0;
            of    = 1'b0;
         end
      endcase
      zf = (val_e == '0);
      sf = sr;
   end

endmodule

// File: rtl/execute_pipe.sv
// Y86-64 execute stage: operand muxes, ALU, CC register, condition eval.
// Ports: E_* from the E register, m_stat/W_stat gate CC; e_* to M; cc_out.
module execute_pipe
   import y86_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       E_stat,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_ifun,
   input  logic [WIDTH-1:0] E_valC,
   input  logic [WIDTH-1:0] E_valA,
   input  logic [WIDTH-1:0] E_valB,
   input  logic [3:0]       E_dstE,
   input  logic [3:0]       E_dstM,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   output logic             e_cnd,
   output logic [3:0]       e_icode,
   output logic [WIDTH-1:0] e_valA,
   output logic [WIDTH-1:0] e_valE,
   output logic [3:0]       e_dstE,
   output logic [3:0]       e_dstM,
   output logic [2:0]       cc_out
);

   localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
   localparam logic [WIDTH-1:0] NEG8 = '0 - POS8;

   logic [WIDTH-1:0] alu_a, alu_b;
   logic [3:0]       alufun;
   logic             zf, sf, of;
   logic             set_cc;
   logic [2:0]       cc;
   logic             c_zf, c_sf, c_of;

   // Status in E does not influence execute; kept as a port for the M reg.
   logic unused_stat;
   assign unused_stat = ^E_stat;

   always_comb begin
      alu_a = '0;
      unique case (1'b1)
         (E_icode == I_RRMOVQ),
         (E_icode == I_OPQ):    alu_a = E_valA;
         (E_icode == I_IRMOVQ),
         (E_icode == I_RMMOVQ),
         (E_icode == I_MRMOVQ): alu_a = E_valC;
         (E_icode == I_CALL),
         (E_icode == I_PUSHQ):  alu_a = NEG8;
         (E_icode == I_RET),
         (E_icode == I_POPQ):   alu_a = POS8;
         default:               alu_a = '0;
      endcase
   end

   always_comb begin
      alu_b = '0;
      unique case (1'b1)
         (E_icode == I_RMMOVQ),
         (E_icode == I_MRMOVQ),
         (E_icode == I_OPQ),
         (E_icode == I_CALL),
         (E_icode == I_PUSHQ),
         (E_icode == I_RET),
         (E_icode == I_POPQ):   alu_b = E_valB;
         default:               alu_b = '0;
      endcase
   end

   assign alufun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

   alu_pipe #(.WIDTH(WIDTH)) u_alu (
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alufun (alufun),
      .val_e  (e_valE),
      .zf     (zf),
      .sf     (sf),
      .of     (of)
   );

   // Undefined OPQ functions leave the flags alone.
   assign set_cc = (E_icode == I_OPQ)
                && (E_ifun <= ALU_XOR)
                && !stat_blocks_cc(m_stat)
                && !stat_blocks_cc(W_stat);

   always_ff @(posedge clk) begin
      if (rst)
         cc <= 3'b100;
      else if (set_cc)
         cc <= {zf, sf, of};
   end

   assign {c_zf, c_sf, c_of} = cc;
   assign cc_out = cc;

   // Conditions read the committed CC, so OPQ->JXX needs no bypass.
   always_comb begin
      e_cnd = 1'b0;
      unique case (E_ifun)
         C_YES:   e_cnd = 1'b1;
         C_LE:    e_cnd = (c_sf ^ c_of) | c_zf;
         C_L:     e_cnd = c_sf ^ c_of;
         C_E:     e_cnd = c_zf;
         C_NE:    e_cnd = !c_zf;
         C_GE:    e_cnd = !(c_sf ^ c_of);
         C_G:     e_cnd = !(c_sf ^ c_of) && !c_zf;
         default: e_cnd = 1'b0;
      endcase
   end

   assign e_dstE  = ((E_icode == I_RRMOVQ) && !e_cnd) ? RNONE : E_dstE;
   assign e_icode = E_icode;
   assign e_valA  = E_valA;
   assign e_dstM  = E_dstM;

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
Execute stage of the 5-stage Y86-64 pipeline. It sits between the E pipeline register and the M pipeline register and holds the architectural condition-code register (ZF/SF/OF). Each cycle it computes e_valE, e_cnd and e_dstE from the E-register outputs. Its e_* outputs feed the M register inputs of the same name directly.

Parameters:
WIDTH, 64, datapath width of valA/valB/valC/valE.

Ports:
clk  in  1  clock; CC register updates on posedge.
rst  in  1  reset; synchronous, active-high.
E_stat  in  3  status of the instruction in E.
E_icode  in  4  instruction code.
E_ifun  in  4  function code (ALU op or condition).
E_valC  in  WIDTH  constant word.
E_valA  in  WIDTH  operand A.
E_valB  in  WIDTH  operand B.
E_dstE  in  4  destination register for valE.
E_dstM  in  4  destination register for memory load.
m_stat  in  3  status currently produced by the memory stage.
W_stat  in  3  status held in the W register.
e_cnd  out  1  condition result for jXX/cmovXX.
e_icode  out  4  E_icode passed through.
e_valA  out  WIDTH  E_valA passed through.
e_valE  out  WIDTH  ALU result.
e_dstE  out  4  E_dstE, or RNONE (0xF) for an untaken cmovXX.
e_dstM  out  4  E_dstM passed through.
cc_out  out  3  {ZF,SF,OF}, registered, for debug and bench visibility.

Behaviour:
- Opcodes: HALT=0, NOP=1, RRMOVQ/CMOVXX=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
- Status codes: AOK=1, HLT=2, ADR=3, INS=4.
- aluA selection:
  - valA for RRMOVQ and OPQ.
  - valC for IRMOVQ, RMMOVQ, MRMOVQ.
  - -8 for CALL and PUSHQ.
  - +8 for RET and POPQ.
  - 0 otherwise.
- aluB selection:
  - valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET, POPQ.
  - 0 for RRMOVQ and IRMOVQ.
  - 0 otherwise.
- ALU function: ifun applies only when icode=OPQ; all other icodes add.
  - ifun 0 = B+A; 1 = B-A; 2 = B&A; 3 = B^A.
  - Any other OPQ ifun yields valE=0 with no CC update.
  - Arithmetic is modulo 2^WIDTH.
- Flags:
  - ZF = (res==0); SF = res[WIDTH-1].
  - ADD: OF = (A sign == B sign) && (res sign != A sign).
  - SUB: OF = (A sign != B sign) && (res sign != B sign).
  - AND/XOR: OF = 0.
- set_cc = (E_icode==OPQ) && m_stat not in {ADR,INS,HLT} && W_stat not in {ADR,INS,HLT}.
- CC register: on posedge, rst → {ZF,SF,OF} = 3'b100; else if set_cc, CC loads the new flags. rst has priority over set_cc.
- Latency:
  - e_valE, e_dstE, e_cnd and pass-throughs are combinational (zero latency).
  - CC written by an OPQ is visible to the next instruction in E one cycle later, so OPQ then JXX/CMOVXX needs no forwarding.
- e_cnd is computed from the registered CC, never from the current ALU flags:
  - 0 always → 1.
  - 1 le → (SF^OF)|ZF.
  - 2 l → SF^OF.
  - 3 e → ZF.
  - 4 ne → !ZF.
  - 5 ge → !(SF^OF).
  - 6 g → !(SF^OF)&!ZF.
  - ifun>6 → 0.
- e_dstE = RNONE when E_icode=RRMOVQ/CMOVXX and !e_cnd; otherwise E_dstE.
- Bubble (icode=NOP, stat=AOK): no CC change, e_dstE=E_dstE (expected 0xF).
- Reset mid-stream: only CC is affected. Combinational outputs keep tracking the E inputs during rst.
- Output reset values: cc_out=3'b100 after the first rst edge. e_cnd after reset for ifun=3 is 1; for ifun=4 it is 0.

Decomposition:
- Package y86_pkg holds:
  - icode constants I_HALT..I_POPQ.
  - ALU ifun constants ALU_ADD/SUB/AND/XOR.
  - condition constants C_YES..C_G.
  - stat constants S_AOK/S_HLT/S_ADR/S_INS.
  - RNONE=4'hF.
- One combinational sub-module, alu_pipe: inputs aluA, aluB, alufun; outputs valE, zf, sf, of.
- execute_pipe contains the operand muxes, set_cc logic, CC register and condition evaluation.

Test Plan:
1. rst=1 for one cycle → cc_out=3'b100. Then JXX ifun=3 → e_cnd=1; ifun=4 → e_cnd=0.
2. OPQ SUB, valA=5, valB=5, stats AOK → e_valE=0, cc_out=100 next cycle. Next instruction CMOVXX ifun=3, E_dstE=2 → e_cnd=1, e_dstE=2.
3. OPQ ADD, valA=valB=0x4000_0000_0000_0000 → e_valE=0x8000_0000_0000_0000, next cc_out=011. Then JXX ifun=1 (le) → e_cnd=0.
4. OPQ XOR with m_stat=ADR → e_valE computed, cc_out unchanged. Repeat with W_stat=HLT → unchanged. Repeat with both AOK → updated.
5. PUSHQ valB=0x100 → e_valE=0xF8. POPQ valB=0x100 → 0x108. MRMOVQ valC=0x10, valB=0x20 → 0x30. IRMOVQ valC=7 → 7. None change CC.
6. Assert rst in the same cycle as an OPQ that would set ZF=0 → cc_out=100. e_icode/e_valA/e_dstM equal their E inputs in every cycle.
